store_merge_unit: RTL and testbench
===================================

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-003 The block SHALL have port start, input, 1 bit: store request from the control unit, sampled only in IDLE.
REQ-004 The block SHALL have port tam, input, 2 bits: store size; 00 sd (8 B), 01 sw (4 B), 10 sh (2 B), 11 sb (1 B).
REQ-005 The block SHALL have port addr, input, 64 bits: byte address of the store (ALUOut).
REQ-006 The block SHALL have port wdata, input, 64 bits: store data (register B); the low 8*size bytes are used.
REQ-007 The block SHALL have port mem_rdata, input, 64 bits: data-memory read data, valid one cycle after mem_addr is presented with mem_wr=0.
REQ-008 The block SHALL have port mem_addr, output, 64 bits: doubleword-aligned address {addr_q[63:3],3'b000}.
REQ-009 The block SHALL have port mem_wr, output, 1 bit: data-memory write enable.
REQ-010 The block SHALL have port mem_wdata, output, 64 bits: full doubleword to write.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port misalign, output, 1 bit: set together with done when the store was rejected.

Function
REQ-014 The block SHALL implement the states IDLE, READ, CAPTURE, WRITE and DONE, with all outputs decoded from registered state (Moore).
REQ-015 In IDLE with start=1, the block SHALL latch addr, wdata and tam into addr_q, wdata_q and tam_q.
REQ-016 From IDLE with start=1, the next state SHALL be DONE if the store is misaligned, WRITE if tam=00, and READ otherwise.
REQ-017 A store SHALL be misaligned when: tam=00 and addr[2:0]≠0; tam=01 and addr[1:0]≠0; tam=10 and addr[0]≠0. An sb store is never misaligned.
REQ-018 In READ, the block SHALL drive mem_addr with mem_wr=0 and then go to CAPTURE.
REQ-019 In CAPTURE, the block SHALL register merged = mem_rdata with only the target bytes replaced, then go to WRITE.
REQ-020 Byte lanes SHALL be little-endian (byte k at bits [8k+7:8k]).
REQ-021 The target bytes SHALL be: sw, bytes 4*addr[2] to 4*addr[2]+3 from wdata_q[31:0]; sh, bytes 2*addr[2:1] and 2*addr[2:1]+1 from wdata_q[15:0]; sb, byte addr[2:0] from wdata_q[7:0].
REQ-022 In WRITE, the block SHALL assert mem_wr=1 for exactly one cycle. mem_wdata SHALL be wdata_q for sd and the merged value otherwise. The next state SHALL be DONE.
REQ-023 In DONE, the block SHALL assert done=1 for one cycle, assert misalign=1 only for a rejected store, and return to IDLE.
REQ-024 Latency from a start cycle t SHALL be: sd has mem_wr at t+1 and done at t+2; sw/sh/sb have the read at t+1, mem_wr at t+3 and done at t+4; a misaligned store has done at t+1 and no mem_wr.
REQ-025 The block SHALL ignore start while busy=1; there is no queueing and latched operands do not change.
REQ-026 start asserted in the DONE cycle SHALL be ignored. start asserted in the following IDLE cycle SHALL be accepted.
REQ-027 mem_wr SHALL be 0 in every state other than WRITE.
REQ-028 mem_wdata SHALL be don't-care outside WRITE but SHALL be held stable.
REQ-029 mem_addr SHALL be driven from addr_q in all states other than IDLE. In IDLE it SHALL be 0.

Reset
REQ-030 With reset=1 at a rising edge, the block SHALL enter IDLE and clear addr_q, wdata_q, tam_q and merged to 0.
REQ-031 During reset, mem_wr, done, misalign and busy SHALL all be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-032 Reset asserted in any state, including WRITE, SHALL abort the operation. mem_wr SHALL be 0 from the next cycle, and no done pulse SHALL follow.
REQ-033 reset SHALL take priority over start in the same cycle.

Verification
REQ-034 The bench SHALL cover an sd store: addr=0x100, wdata=0x1122334455667788, tam=00 -> mem_wr at t+1 with mem_addr=0x100 and mem_wdata=0x1122334455667788; done at t+2 with misalign=0.
REQ-035 The bench SHALL cover an sw store to the upper word: addr=0x104, wdata=0xFFFFFFFFAABBCCDD, mem_rdata=0x0123456789ABCDEF -> mem_wr at t+3 with mem_addr=0x100 and mem_wdata=0xAABBCCDD89ABCDEF.
REQ-036 The bench SHALL cover an sb store: addr=0x203, wdata=0x5A, mem_rdata=0 -> mem_wdata=0x000000005A000000; for sh at addr=0x206 with wdata=0xBEEF and mem_rdata=0 -> mem_wdata=0xBEEF000000000000.
REQ-037 The bench SHALL cover a misaligned store: sw at addr=0x102 -> done=1 and misalign=1 at t+1, and mem_wr stays 0 throughout.
REQ-038 The bench SHALL cover start held high for 6 cycles with tam=11 -> exactly one store is accepted, the second is accepted in the IDLE cycle after DONE, and operands are unchanged while busy.
REQ-039 The bench SHALL cover reset asserted in CAPTURE of an sh store -> IDLE next cycle, with no mem_wr and no done; a following sd store completes normally.

Source files
------------

// File: rtl/store_merge_unit.sv
// Store path for sd/sw/sh/sb. Partial stores do a read-modify-write of the
// enclosing doubleword; misaligned stores are rejected without touching memory.
module store_merge_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  tam,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   input  logic [63:0] mem_rdata,
   output logic [63:0] mem_addr,
   output logic        mem_wr,
   output logic [63:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        misalign
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE} state_t;

   state_t      r_state;
   logic [63:0] r_addr_q;
   logic [63:0] r_wdata_q;
   logic [63:0] r_merged;
   logic [1:0]  r_tam_q;
   logic        r_rej;

   logic        w_mis;
   logic [7:0]  w_mask;
   logic [63:0] w_shdata;
   logic [63:0] w_merge;

   always_comb begin
      case (tam)
         2'b00:   w_mis = (addr[2:0] != 3'd0);
         2'b01:   w_mis = (addr[1:0] != 2'd0);
         2'b10:   w_mis = addr[0];
         default: w_mis = 1'b0;
      endcase
   end

   // Accepted partial stores are naturally aligned, so shifting the data and
   // the lane mask by the byte offset lands them on the right lanes.
   always_comb begin
      case (r_tam_q)
         2'b01:   w_mask = 8'h0F << r_addr_q[2:0];
         2'b10:   w_mask = 8'h03 << r_addr_q[2:0];
         2'b11:   w_mask = 8'h01 << r_addr_q[2:0];
         default: w_mask = 8'h00;
      endcase
   end

   assign w_shdata = r_wdata_q << {r_addr_q[2:0], 3'b000};

   for (genvar k = 0; k < 8; k++) begin : g_lane
      assign w_merge[8*k +: 8] = w_mask[k] ? w_shdata[8*k +: 8] : mem_rdata[8*k +: 8];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_addr_q  <= '0;
         r_wdata_q <= '0;
         r_merged  <= '0;
         r_tam_q   <= '0;
         r_rej     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_addr_q  <= addr;
                  r_wdata_q <= wdata;
                  r_tam_q   <= tam;
                  r_rej     <= w_mis;
                  if (w_mis)               r_state <= S_DONE;
                  else if (tam == 2'b00)   r_state <= S_WRITE;
                  else                     r_state <= S_READ;
               end
            end
            S_READ:    r_state <= S_CAPTURE;
            S_CAPTURE: begin
               r_merged <= w_merge;
               r_state  <= S_WRITE;
            end
            S_WRITE:   r_state <= S_DONE;
            S_DONE:    r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign mem_wr    = (r_state == S_WRITE);
   assign done      = (r_state == S_DONE);
   assign misalign  = done & r_rej;
   assign mem_addr  = busy ? {r_addr_q[63:3], 3'b000} : 64'd0;
   assign mem_wdata = (r_tam_q == 2'b00) ? r_wdata_q : r_merged;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: timeline model checked every cycle plus
// literal expectations for the directed stores.
module tb_store_merge_unit;

   localparam logic [63:0] GARB = 64'hDEAD_BEEF_DEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [1:0]  tam;
   logic [63:0] addr, wdata, mem_rdata;
   logic [63:0] mem_addr, mem_wdata;
   logic        mem_wr, busy, done, misalign;

   store_merge_unit dut (
      .clk(clk), .reset(reset), .start(start), .tam(tam), .addr(addr),
      .wdata(wdata), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
      .mem_wr(mem_wr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
      .misalign(misalign)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic chk_en = 1'b0;
   logic [63:0] rd_val = 64'd0;

   int          wr_cyc[$];
   logic [63:0] wr_dat[$];
   logic [63:0] wr_adr[$];
   int          dn_cyc[$];
   logic        dn_mis[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: what memory must receive for a store, from the byte-lane rules.
   function automatic logic [63:0] exp_merge(input logic [1:0] t, input logic [63:0] a,
                                             input logic [63:0] wd, input logic [63:0] rd);
      logic [63:0] r;
      int n, off;
      n   = 1 << (3 - t);
      off = int'(a[2:0]);
      if (t == 2'b00) return wd;
      r = rd;
      for (int b = 0; b < n; b++) r[8*(off+b) +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // Model: offset (in cycles) since acceptance, and total latency of the op.
   int          m_off = 0;
   int          m_lat = 0;
   logic        m_mis = 1'b0;
   logic [63:0] m_addr = '0;
   logic [63:0] m_wd = '0;

   always @(posedge clk) begin
      if (reset) m_off <= 0;
      else if (m_off == 0) begin
         if (start) begin
            logic bad;
            bad = (int'(addr[2:0]) & ((1 << (3 - tam)) - 1)) != 0;
            m_off  <= 1;
            m_mis  <= bad;
            m_lat  <= bad ? 1 : (tam == 2'b00 ? 2 : 4);
            m_addr <= addr;
            m_wd   <= exp_merge(tam, addr, wdata, rd_val);
         end
      end else if (m_off == m_lat) m_off <= 0;
      else m_off <= m_off + 1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic e_busy, e_done, e_wr;
         e_busy = (m_off != 0);
         e_done = e_busy && (m_off == m_lat);
         e_wr   = e_busy && !m_mis && (m_off == m_lat - 1);
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("mem_wr", mem_wr, e_wr);
         chk("misalign", misalign, e_done && m_mis);
         chk("mem_addr", mem_addr, e_busy ? {m_addr[63:3], 3'b000} : 64'd0);
         if (e_wr) chk("mem_wdata", mem_wdata, m_wd);
         if (mem_wr === 1'b1) begin
            wr_cyc.push_back(cyc); wr_dat.push_back(mem_wdata); wr_adr.push_back(mem_addr);
         end
         if (done === 1'b1) begin
            dn_cyc.push_back(cyc); dn_mis.push_back(misalign);
         end
      end
   end

   // Memory answers a read one cycle after the address is presented.
   task automatic step();
      logic [63:0] nx;
      nx = (busy === 1'b1 && mem_wr === 1'b0) ? rd_val : GARB;
      @(posedge clk);
      #1;
      mem_rdata = nx;
   endtask

   task automatic clear_logs();
      wr_cyc.delete(); wr_dat.delete(); wr_adr.delete(); dn_cyc.delete(); dn_mis.delete();
   endtask

   task automatic launch(input logic [1:0] t, input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] rd, output int t0);
      rd_val = rd; tam = t; addr = a; wdata = wd; start = 1'b1;
      t0 = cyc;
      clear_logs();
      step();
      start = 1'b0;
      repeat (6) step();
   endtask

   task automatic expect_one(input string nm, input int t0, input int wr_off,
                             input logic [63:0] e_addr, input logic [63:0] e_data,
                             input int dn_off, input logic e_mis);
      chk({nm, "_nwr"}, wr_cyc.size(), (wr_off < 0) ? 0 : 1);
      if (wr_off >= 0 && wr_cyc.size() == 1) begin
         chk({nm, "_wrcyc"}, wr_cyc[0], t0 + wr_off);
         chk({nm, "_wraddr"}, wr_adr[0], e_addr);
         chk({nm, "_wrdata"}, wr_dat[0], e_data);
      end
      chk({nm, "_ndone"}, dn_cyc.size(), 1);
      if (dn_cyc.size() == 1) begin
         chk({nm, "_donecyc"}, dn_cyc[0], t0 + dn_off);
         chk({nm, "_mis"}, dn_mis[0], e_mis);
      end
   endtask

   initial begin
      int t0;
      reset = 1'b1; start = 1'b0; tam = 2'b00; addr = '0; wdata = '0; mem_rdata = GARB;
      repeat (3) step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_wr", mem_wr, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_mis", misalign, 1'b0);
      chk("rst_addr", mem_addr, 64'd0);
      chk("rst_wdata", mem_wdata, 64'd0);
      chk_en = 1'b1;
      reset = 1'b0;
      step();

      launch(2'b00, 64'h100, 64'h1122334455667788, 64'd0, t0);
      expect_one("sd", t0, 1, 64'h100, 64'h1122334455667788, 2, 1'b0);

      launch(2'b01, 64'h104, 64'hFFFFFFFFAABBCCDD, 64'h0123456789ABCDEF, t0);
      expect_one("sw_hi", t0, 3, 64'h100, 64'hAABBCCDD89ABCDEF, 4, 1'b0);

      launch(2'b11, 64'h203, 64'h5A, 64'd0, t0);
      expect_one("sb", t0, 3, 64'h200, 64'h000000005A000000, 4, 1'b0);

      launch(2'b10, 64'h206, 64'hBEEF, 64'd0, t0);
      expect_one("sh", t0, 3, 64'h200, 64'hBEEF000000000000, 4, 1'b0);

      launch(2'b01, 64'h102, 64'h12345678, 64'd0, t0);
      expect_one("sw_mis", t0, -1, 64'd0, 64'd0, 1, 1'b1);

      launch(2'b10, 64'h201, 64'hABCD, 64'd0, t0);
      expect_one("sh_mis", t0, -1, 64'd0, 64'd0, 1, 1'b1);

      // start held for six cycles; operands change while busy
      rd_val = 64'hFFFFFFFFFFFFFFFF; tam = 2'b11; addr = 64'h301; wdata = 64'h11; start = 1'b1;
      t0 = cyc;
      clear_logs();
      step();
      addr = 64'h305; wdata = 64'h22;
      repeat (5) step();
      start = 1'b0;
      repeat (5) step();
      chk("hold_nwr", wr_cyc.size(), 2);
      chk("hold_ndone", dn_cyc.size(), 2);
      if (wr_cyc.size() == 2) begin
         chk("hold_wr0cyc", wr_cyc[0], t0 + 3);
         chk("hold_wr0data", wr_dat[0], 64'hFFFFFFFFFFFF11FF);
         chk("hold_wr0addr", wr_adr[0], 64'h300);
         chk("hold_wr1cyc", wr_cyc[1], t0 + 8);
         chk("hold_wr1data", wr_dat[1], 64'hFFFF22FFFFFFFFFF);
      end
      if (dn_cyc.size() == 2) chk("hold_dn1cyc", dn_cyc[1], t0 + 9);

      // reset (with a competing start) during CAPTURE of an sh store
      rd_val = 64'd0; tam = 2'b10; addr = 64'h206; wdata = 64'hBEEF; start = 1'b1;
      t0 = cyc;
      clear_logs();
      step();
      start = 1'b0;
      step();
      reset = 1'b1; start = 1'b1; tam = 2'b00; addr = 64'h400;
      step();
      chk("abort_busy", busy, 1'b0);
      chk("abort_addr", mem_addr, 64'd0);
      reset = 1'b0; start = 1'b0;
      repeat (5) step();
      chk("abort_nwr", wr_cyc.size(), 0);
      chk("abort_ndone", dn_cyc.size(), 0);

      launch(2'b00, 64'h108, 64'hCAFEF00D12345678, 64'd0, t0);
      expect_one("sd_after", t0, 1, 64'h108, 64'hCAFEF00D12345678, 2, 1'b0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
